// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC sequencer state encoding, default PC width and
// the control-flow opcodes the decoder and sequencer agree on.
package cpu_pkg;

    // Default instruction address width (ROM depth 2^8).
    localparam int unsigned DefaultPcW = 8;

    // Opcode field of the 9-bit instruction word.
    localparam int unsigned OpcodeW = 4;

    localparam logic [OpcodeW-1:0] OpHalt   = 4'hF;
    localparam logic [OpcodeW-1:0] OpBr     = 4'hC;
    localparam logic [OpcodeW-1:0] OpBrEven = 4'hD;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/fetch bundle between the decode/branch logic and the PC sequencer.
// Optional macro PC_SEQ_PERF_EN adds the retired-instruction counter readout.
interface pc_sequencer_if #(
    parameter int unsigned PC_W = cpu_pkg::DefaultPcW
);

    logic            start;
    logic [PC_W-1:0] start_addr;
    logic            stall;
    logic            halt_req;
    logic            br_taken;
    logic [PC_W-1:0] br_target;

    logic [PC_W-1:0] inst_addr;
    logic            exec_en;
    logic            running;
    logic            done;
    logic            fault;
`ifdef PC_SEQ_PERF_EN
    logic [15:0]     retired_cnt;
`endif

    // Decoder / control side.
    modport master (
        output start,
        output start_addr,
        output stall,
        output halt_req,
        output br_taken,
        output br_target,
        input  inst_addr,
        input  exec_en,
        input  running,
        input  done,
        input  fault
`ifdef PC_SEQ_PERF_EN
        ,
        input  retired_cnt
`endif
    );

    // Sequencer side.
    modport slave (
        input  start,
        input  start_addr,
        input  stall,
        input  halt_req,
        input  br_taken,
        input  br_target,
        output inst_addr,
        output exec_en,
        output running,
        output done,
        output fault
`ifdef PC_SEQ_PERF_EN
        ,
        output retired_cnt
`endif
    );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection for the RUN state, with address-space
// overrun detection on the pre-increment PC (no wrap-around allowed).
module pc_next_sel #(
    parameter int unsigned PC_W = cpu_pkg::DefaultPcW
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic            stall_i,
    input  logic            halt_req_i,
    input  logic            br_taken_i,
    input  logic [PC_W-1:0] br_target_i,
    output logic [PC_W-1:0] pc_next_o,
    output logic            overrun_o
);

    // Priority: stall, halt, branch, overrun, sequential increment.
    always_comb begin
        pc_next_o = pc_i;
        overrun_o = 1'b0;
        if (stall_i || halt_req_i) begin
            pc_next_o = pc_i;
        end else if (br_taken_i) begin
            pc_next_o = br_target_i;
        end else if (pc_i == '1) begin
            // Last ROM word executed with nowhere to go: hold and flag.
            overrun_o = 1'b1;
        end else begin
            pc_next_o = pc_i + 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the ROM fetch address, launches programs
// from a selectable entry point, branches, and stops on HALT or PC overrun.
// Optional macro PC_SEQ_PERF_EN adds a saturating retired-instruction counter.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W       = DefaultPcW,
    parameter int unsigned RESET_ADDR = 0
) (
    input logic           CLK,
    input logic           reset,
    pc_sequencer_if.slave bus
);

    localparam logic [PC_W-1:0] ResetPc = PC_W'(RESET_ADDR);

    pc_state_t       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_next;
    logic            fault_q, fault_d;
    logic            overrun;
    logic            running;
    logic            exec_en;

    pc_next_sel #(
        .PC_W (PC_W)
    ) u_next_sel (
        .pc_i        (pc_q),
        .stall_i     (bus.stall),
        .halt_req_i  (bus.halt_req),
        .br_taken_i  (bus.br_taken),
        .br_target_i (bus.br_target),
        .pc_next_o   (pc_next),
        .overrun_o   (overrun)
    );

    // State, PC and fault registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= ResetPc;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    // Next-state, next-PC and fault logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    pc_d    = bus.start_addr;
                    state_d = StRun;
                end
            end
            StRun: begin
                pc_d = pc_next;
                if (!bus.stall && bus.halt_req) begin
                    state_d = StHalted;
                end else if (overrun) begin
                    state_d = StHalted;
                    fault_d = 1'b1;
                end
            end
            StHalted: begin
                if (bus.start) begin
                    fault_d = 1'b0;
                    pc_d    = bus.start_addr;
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StIdle;
                pc_d    = ResetPc;
            end
        endcase
    end

    assign running = (state_q == StRun);
    // Only combinational input-to-output path: stall suppresses commit.
    assign exec_en = running && !bus.stall;

    assign bus.inst_addr = pc_q;
    assign bus.running   = running;
    assign bus.exec_en   = exec_en;
    assign bus.done      = (state_q == StHalted);
    assign bus.fault     = fault_q;

`ifdef PC_SEQ_PERF_EN
    logic [15:0] retired_q;

    // Saturating commit counter; a start is only accepted outside RUN.
    always_ff @(posedge CLK) begin
        if (reset) begin
            retired_q <= '0;
        end else if (bus.start && !running) begin
            retired_q <= '0;
        end else if (exec_en && (retired_q != 16'hFFFF)) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    assign bus.retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: table of per-cycle vectors whose
// expected outputs are queued on drive and compared after the clock settles,
// plus hand-written overrun / restart sequences.
module tb_pc_sequencer;

    logic CLK;
    logic reset;

    pc_sequencer_if #(.PC_W(8)) bus ();

    pc_sequencer #(
        .PC_W       (8),
        .RESET_ADDR (0)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        start;
        logic [7:0]  saddr;
        logic        stall;
        logic        halt;
        logic        br;
        logic [7:0]  btgt;
        logic        chk;
        logic [7:0]  e_addr;
        logic        e_run;
        logic        e_done;
        logic        e_fault;
        logic        e_exec;
        logic [15:0] e_ret;
        int          idx;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   ret_acc;
    int   n_checks;
    int   n_errors;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Append one vector; expected outputs describe the cycle the inputs are applied in.
    task automatic add(input int rst, input int start, input int saddr, input int stall,
                       input int halt, input int br, input int btgt, input int chk,
                       input int ea, input int er, input int ed, input int ef, input int ex);
        vec_t v;
        v.rst     = 1'(rst);
        v.start   = 1'(start);
        v.saddr   = 8'(saddr);
        v.stall   = 1'(stall);
        v.halt    = 1'(halt);
        v.br      = 1'(br);
        v.btgt    = 8'(btgt);
        v.chk     = 1'(chk);
        v.e_addr  = 8'(ea);
        v.e_run   = 1'(er);
        v.e_done  = 1'(ed);
        v.e_fault = 1'(ef);
        v.e_exec  = 1'(ex);
        v.e_ret   = 16'(ret_acc);
        v.idx     = tbl.size();
        if (rst != 0) ret_acc = 0;
        else if (start != 0 && er == 0) ret_acc = 0;
        else if (ex != 0) ret_acc++;
        tbl.push_back(v);
    endtask

    // Straight-line execution from PC 'from' to 'to'.
    task automatic seq(input int from, input int to);
        for (int a = from; a <= to; a++) add(0, 0, 0, 0, 0, 0, 0, 1, a, 1, 0, 0, 1);
    endtask

    task automatic apply(input vec_t v);
        @(negedge CLK);
        reset          = v.rst;
        bus.start      = v.start;
        bus.start_addr = v.saddr;
        bus.stall      = v.stall;
        bus.halt_req   = v.halt;
        bus.br_taken   = v.br;
        bus.br_target  = v.btgt;
        exp_q.push_back(v);
    endtask

    // Scoreboard: compare each queued expectation once outputs have settled.
    always @(negedge CLK) begin : scoreboard
        vec_t v;
        #2;
        if (exp_q.size() != 0) begin
            v = exp_q.pop_front();
            if (v.chk) begin
                check($sformatf("v%0d inst_addr", v.idx), 16'(bus.inst_addr), 16'(v.e_addr));
                check($sformatf("v%0d running", v.idx), 16'(bus.running), 16'(v.e_run));
                check($sformatf("v%0d done", v.idx), 16'(bus.done), 16'(v.e_done));
                check($sformatf("v%0d fault", v.idx), 16'(bus.fault), 16'(v.e_fault));
                check($sformatf("v%0d exec_en", v.idx), 16'(bus.exec_en), 16'(v.e_exec));
`ifdef PC_SEQ_PERF_EN
                check($sformatf("v%0d retired_cnt", v.idx), bus.retired_cnt, v.e_ret);
`endif
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : main
        int  n_exec;
        bit  got_done;

        n_checks       = 0;
        n_errors       = 0;
        ret_acc        = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.stall      = 1'b0;
        bus.halt_req   = 1'b0;
        bus.br_taken   = 1'b0;
        bus.br_target  = '0;

        //   rst st saddr stl hlt br tgt chk addr run dn flt ex
        add(1, 0, 0,   0, 0, 0, 0,  0, 0,   0, 0, 0, 0);
        add(0, 0, 0,   0, 0, 0, 0,  1, 0,   0, 0, 0, 0);
        add(0, 0, 0,   0, 1, 1, 9,  1, 0,   0, 0, 0, 0);   // decoder ignored in IDLE
        add(0, 0, 0,   1, 0, 0, 0,  1, 0,   0, 0, 0, 0);
        add(0, 1, 0,   0, 0, 0, 0,  1, 0,   0, 0, 0, 0);   // launch at 0
        seq(0, 10);
        add(0, 0, 0,   0, 0, 1, 5,  1, 11,  1, 0, 0, 1);   // branch 11 -> 5
        seq(5, 19);
        repeat (3) add(0, 0, 0, 1, 0, 1, 40, 1, 20, 1, 0, 0, 0); // stall masks branch
        seq(20, 29);
        add(0, 0, 0,   1, 1, 0, 0,  1, 30,  1, 0, 0, 0);   // stall masks halt
        add(0, 1, 99,  0, 0, 0, 0,  1, 30,  1, 0, 0, 1);   // start ignored in RUN
        seq(31, 74);
        add(0, 0, 0,   0, 1, 1, 3,  1, 75,  1, 0, 0, 1);   // halt beats branch
        add(0, 0, 0,   0, 1, 1, 3,  1, 75,  0, 1, 0, 0);
        add(0, 1, 6,   0, 0, 0, 0,  1, 75,  0, 1, 0, 0);   // restart from HALTED
        seq(6, 7);
        add(0, 0, 0,   0, 0, 1, 8,  1, 8,   1, 0, 0, 1);   // branch to self
        add(0, 0, 0,   0, 0, 1, 8,  1, 8,   1, 0, 0, 1);
        add(0, 0, 0,   0, 1, 0, 0,  1, 8,   1, 0, 0, 1);
        add(0, 1, 254, 0, 0, 0, 0,  1, 8,   0, 1, 0, 0);
        seq(254, 255);
        add(0, 0, 0,   0, 0, 0, 0,  1, 255, 0, 1, 1, 0);   // overrun halt
        add(0, 1, 250, 0, 0, 0, 0,  1, 255, 0, 1, 1, 0);
        seq(250, 251);
        add(1, 1, 9,   0, 1, 1, 3,  1, 252, 1, 0, 0, 1);   // reset beats everything
        add(0, 0, 0,   0, 0, 0, 0,  1, 0,   0, 0, 0, 0);
        add(0, 1, 0,   0, 0, 0, 0,  1, 0,   0, 0, 0, 0);   // 0..75 with two stalls
        seq(0, 9);
        add(0, 0, 0,   1, 0, 0, 0,  1, 10,  1, 0, 0, 0);
        seq(10, 39);
        add(0, 0, 0,   1, 0, 0, 0,  1, 40,  1, 0, 0, 0);
        seq(40, 74);
        add(0, 0, 0,   0, 1, 0, 0,  1, 75,  1, 0, 0, 1);
        add(0, 0, 0,   0, 0, 0, 0,  1, 75,  0, 1, 0, 0);
        add(0, 1, 6,   0, 0, 0, 0,  1, 75,  0, 1, 0, 0);
        seq(6, 6);
        add(1, 0, 0,   0, 0, 0, 0,  1, 7,   1, 0, 0, 1);
        add(0, 0, 0,   0, 0, 0, 0,  1, 0,   0, 0, 0, 0);

        foreach (tbl[i]) apply(tbl[i]);
        @(negedge CLK);
        bus.start = 1'b0;
        #3;

        // Overrun from 200 with intermittent stalls: 56 commits then fault.
        reset = 1'b1;
        @(negedge CLK);
        reset          = 1'b0;
        bus.start      = 1'b1;
        bus.start_addr = 8'd200;
        bus.halt_req   = 1'b0;
        bus.br_taken   = 1'b0;
        bus.stall      = 1'b0;
        @(negedge CLK);
        bus.start = 1'b0;
        n_exec    = 0;
        got_done  = 1'b0;
        for (int i = 0; i < 120; i++) begin
            #2;
            if (bus.done) begin
                got_done = 1'b1;
                break;
            end
            if (bus.exec_en) n_exec++;
            @(negedge CLK);
            bus.stall = ((i % 7) == 3);
        end
        bus.stall = 1'b0;
        if (!got_done) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: done not seen within 120 cycles, required 1");
        end
        check("ovr commits", 16'(n_exec), 16'd56);
        check("ovr inst_addr", 16'(bus.inst_addr), 16'd255);
        check("ovr fault", 16'(bus.fault), 16'd1);
        check("ovr running", 16'(bus.running), 16'd0);
`ifdef PC_SEQ_PERF_EN
        check("ovr retired_cnt", bus.retired_cnt, 16'd56);
`endif

        // Restart after fault: fault clears, new PC, counter cleared.
        @(negedge CLK);
        bus.start      = 1'b1;
        bus.start_addr = 8'd3;
        @(negedge CLK);
        bus.start = 1'b0;
        #2;
        check("restart inst_addr", 16'(bus.inst_addr), 16'd3);
        check("restart fault", 16'(bus.fault), 16'd0);
        check("restart exec_en", 16'(bus.exec_en), 16'd1);
`ifdef PC_SEQ_PERF_EN
        check("restart retired_cnt", bus.retired_cnt, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
